// File: rtl/brlite_svc_queue.sv
// brlite_svc_queue: req/ack receive buffer holding BrLite service messages for the DMNI.
package brlite_svc_pkg;
  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] producer;
    logic [15:0] seq_source;
    logic [31:0] payload;
  } brlite_svc_t;
endpackage

module brlite_svc_queue
  import brlite_svc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rx_req_i,
  output logic                     rx_ack_o,
  input  brlite_svc_t              rx_data_i,
  output logic                     svc_rx_o,
  input  logic                     svc_ack_i,
  output brlite_svc_t              svc_data_o,
  output logic [$clog2(DEPTH):0]   svc_count_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;
  state_t          r_state, w_next;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  brlite_svc_t     r_mem [DEPTH];
  logic            w_push, w_pop;
  // admission uses the registered count, so a same-cycle pop never frees room for a push
  assign w_push = (r_state == IDLE) && rx_req_i && (r_count < FULL_CNT);
  assign w_pop  = svc_ack_i && (r_count != '0);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_push ? ACK : IDLE;
      ACK:      w_next = WAIT_REL;
      WAIT_REL: w_next = rx_req_i ? WAIT_REL : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    rx_ack_o = (r_state == ACK);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= rx_data_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  assign svc_rx_o    = (r_count != '0);
  assign svc_data_o  = r_mem[r_rd_ptr];
  assign svc_count_o = r_count;
  assign full_o      = (r_count == FULL_CNT);
endmodule

// File: tb/tb_brlite_svc_queue.sv
// tb_brlite_svc_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_brlite_svc_queue;
  import brlite_svc_pkg::*;
  localparam int DEPTH = 4;
  logic        clk, rst, rx_req, rx_ack, svc_rx, svc_ack, full;
  brlite_svc_t rx_data, svc_data;
  logic [2:0]  svc_count;
  int          n_chk, n_fail;
  brlite_svc_t q[$];
  bit          m_ack, m_hold;

  brlite_svc_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .rx_req_i(rx_req), .rx_ack_o(rx_ack), .rx_data_i(rx_data),
    .svc_rx_o(svc_rx), .svc_ack_i(svc_ack), .svc_data_o(svc_data),
    .svc_count_o(svc_count), .full_o(full)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("ack", rx_ack, m_ack);
    chk("svc_rx", svc_rx, q.size() != 0);
    chk("count", svc_count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("bound", svc_count <= DEPTH, 1);
    if (q.size() > 0) chk("head", svc_data, q[0]);
  endtask

  // Reference: one accept per held request; the ack cycle and a low-req cycle must pass before the next.
  task automatic tick();
    bit pre_full;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_ack = 0; m_hold = 0;
    end else begin
      pre_full = q.size() >= DEPTH;
      if (svc_ack && q.size() > 0) void'(q.pop_front());
      if (m_ack) begin m_ack = 0; m_hold = 1; end
      else if (m_hold) m_hold = rx_req;
      else if (rx_req && !pre_full) begin q.push_back(rx_data); m_ack = 1; end
    end
    #1 compare();
  endtask

  task automatic send(input logic [31:0] p);
    rx_data = '{ksvc: 8'h12, producer: 16'h0101, seq_source: 16'h0003, payload: p};
    rx_req = 1;
  endtask

  task automatic handshake(input logic [31:0] p);
    send(p); tick(); rx_req = 0; tick(); tick();
  endtask

  task automatic pop_chk(input logic [31:0] p);
    chk("pop_data", svc_data.payload, p);
    svc_ack = 1; tick(); svc_ack = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1; rx_req = 0; svc_ack = 0; rx_data = '0;
    tick(); tick();
    chk("rst_data", svc_data, 0);
    #2 rst = 0;
    tick();
    // single message
    send(32'hDEADBEEF);
    tick();
    chk("single_ack", rx_ack, 1);
    rx_req = 0; tick();
    chk("single_ack_off", rx_ack, 0);
    chk("single_data", svc_data, {8'h12, 16'h0101, 16'h0003, 32'hDEADBEEF});
    chk("single_cnt", svc_count, 1);
    tick();
    pop_chk(32'hDEADBEEF);
    chk("single_empty", svc_rx, 0);
    // fill and back-pressure
    for (int p = 1; p <= 4; p++) handshake(p);
    chk("fill_full", full, 1);
    send(5);
    repeat (4) begin tick(); chk("bp_noack", rx_ack, 0); end
    svc_ack = 1; tick(); svc_ack = 0;
    tick(); tick();
    chk("bp_cnt", svc_count, 4);
    rx_req = 0; tick(); tick();
    for (int p = 2; p <= 5; p++) pop_chk(p);
    // held request
    send(10);
    repeat (12) tick();
    chk("held_cnt", svc_count, 1);
    rx_req = 0; tick(); tick();
    send(11); tick();
    chk("rearm_cnt", svc_count, 2);
    rx_req = 0; tick(); tick();
    // simultaneous push/pop at count 2, then at full
    send(12); svc_ack = 1; tick(); svc_ack = 0;
    chk("sim_cnt", svc_count, 2);
    rx_req = 0; tick(); tick();
    handshake(13); handshake(14);
    chk("sim_full", full, 1);
    send(15); svc_ack = 1; tick(); svc_ack = 0;
    chk("defer_noack", rx_ack, 0);
    tick();
    chk("defer_ack", rx_ack, 1);
    rx_req = 0; tick(); tick();
    for (int p = 12; p <= 15; p++) pop_chk(p);
    // pop on empty
    svc_ack = 1; tick(); svc_ack = 0;
    chk("empty_pop", svc_count, 0);
    handshake(30);
    pop_chk(30);
    // reset mid-handshake with count 3
    handshake(20); handshake(21);
    send(22); tick();
    chk("pre_rst_cnt", svc_count, 3);
    #2 rst = 1;
    #1;
    q.delete(); m_ack = 0; m_hold = 0;
    chk("rst_ack", rx_ack, 0);
    chk("rst_rx", svc_rx, 0);
    chk("rst_cnt", svc_count, 0);
    chk("rst_full", full, 0);
    chk("rst_head", svc_data, 0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_cnt", svc_count, 1);
    rx_req = 0; tick(); tick();
    pop_chk(22);
    // wrap-around: 3*DEPTH ordered push/pop
    for (int p = 100; p < 100 + 3 * DEPTH; p++) begin
      handshake(p);
      pop_chk(p);
    end
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!rx_req && $urandom_range(0, 2) == 0) begin
        rx_data = brlite_svc_t'({$urandom, $urandom, $urandom});
        rx_req = 1;
      end else if (rx_req && (m_ack || m_hold) && $urandom_range(0, 1) == 0) rx_req = 0;
      svc_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
